cpld_bus_sequencer: RTL

FPGA-side controller for the CPLD breakout link. It watches the Z80 activity strobe `ACT` and sequences the 3-bit `CMD` bus to read control signals, address and data from the CPLD. It checks the CPLD parity bits and hands each Z80 cycle to the host as a descriptor. It then drives the host's read data back through `CMD_WR_BUS`, and serialises host register writes (`CMD_WR_REG`: LED, INT, reset) onto the same link.

---
 rtl/cpld_link_pkg.sv | 30 +++
 rtl/act_sync.sv | 19 +
 rtl/cpld_bus_sequencer.sv | 96 +++++++++
 3 files changed

// File: rtl/cpld_link_pkg.sv
// cpld_link_pkg: link command codes, signals-byte layout, sequencer states and per-state bus drive
package cpld_link_pkg;
  localparam logic [2:0] CMD_RD_SIGNALS = 3'b000;
  localparam logic [2:0] CMD_RD_LOW     = 3'b001;
  localparam logic [2:0] CMD_RD_HIGH    = 3'b010;
  localparam logic [2:0] CMD_RD_BUS     = 3'b011;
  localparam logic [2:0] CMD_WR_BUS     = 3'b100;
  localparam logic [2:0] CMD_WR_REG     = 3'b101;
  localparam logic [2:0] CMD_TURN       = 3'b110;
  localparam int SIG_APAR = 7;
  localparam int SIG_DPAR = 6;
  localparam int SIG_MREQ = 2;
  localparam int SIG_RD   = 1;
  localparam int SIG_M1   = 0;
  typedef enum logic [3:0] {
    S_IDLE, S_SIG, S_LO, S_HI, S_BUS, S_CHECK, S_PUSH, S_RSP, S_WRB, S_REGW, S_REL
  } state_t;
  function automatic logic [2:0] cmd_of(state_t s, logic [7:0] t);
    return s == S_SIG ? CMD_RD_SIGNALS :
           s == S_LO  ? CMD_RD_LOW :
           s == S_HI  ? CMD_RD_HIGH :
           s == S_BUS ? CMD_RD_BUS :
           (s != S_WRB && s != S_REGW) ? CMD_RD_SIGNALS :
           t == 8'd2 ? (s == S_WRB ? CMD_WR_BUS : CMD_WR_REG) :
           t == 8'd4 ? CMD_RD_SIGNALS : CMD_TURN;
  endfunction
  function automatic logic oe_of(state_t s, logic [7:0] t);
    return (s == S_WRB || s == S_REGW) && t >= 8'd1 && t <= 8'd3;
  endfunction
endpackage

// File: rtl/act_sync.sv
// act_sync: two-flop synchronizer for the Z80 activity strobe with edge pulses, idle-high
module act_sync (
  input  logic CLK,
  input  logic RST,
  input  logic ACT,
  output logic lvl,
  output logic fall,
  output logic rise
);
  logic s1, s2, s3;
  // shift the strobe through two sync stages plus one edge-detect stage
  always_ff @(posedge CLK) begin
    if (RST) {s1, s2, s3} <= 3'b111;
    else {s1, s2, s3} <= {ACT, s1, s2};
  end
  assign lvl  = s2;
  assign fall = s3 & ~s2;
  assign rise = ~s3 & s2;
endmodule

// File: rtl/cpld_bus_sequencer.sv
// cpld_bus_sequencer: reads Z80 cycles from the CPLD, hands them to the host, writes data back
module cpld_bus_sequencer
  import cpld_link_pkg::*;
#(
  parameter int SETTLE    = 2,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ACT,
  output logic [2:0]  CMD,
  input  logic [7:0]  D_IN,
  output logic [7:0]  D_OUT,
  output logic        D_OE,
  output logic        cyc_valid,
  input  logic        cyc_ready,
  output logic [15:0] cyc_addr,
  output logic [7:0]  cyc_data,
  output logic        cyc_is_io,
  output logic        cyc_is_wr,
  output logic        cyc_m1,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_data,
  output logic        rsp_ready,
  input  logic        reg_req,
  input  logic [7:0]  reg_data,
  output logic        reg_ack,
  output logic        err_parity,
  output logic        err_timeout
);
  state_t state, state_nxt;
  logic [7:0] cnt, cnt_nxt, sig, lo, hi, dat, retry;
  logic [15:0] tmo;
  logic [2:0] sig_unused;
  logic act_lvl, act_fall, act_rise, last, par_ok, tmo_hit, start;
  act_sync u_sync (.CLK(CLK), .RST(RST), .ACT(ACT), .lvl(act_lvl), .fall(act_fall), .rise(act_rise));
  assign cyc_addr   = {hi, lo};
  assign cyc_data   = dat;
  assign cyc_is_io  = sig[SIG_MREQ];
  assign cyc_is_wr  = sig[SIG_RD];
  assign cyc_m1     = ~sig[SIG_M1];
  assign sig_unused = sig[5:3];
  assign last    = cnt == 8'(SETTLE - 1);
  assign tmo_hit = (state == S_PUSH || state == S_RSP) && tmo == 16'(TIMEOUT);
  assign start   = state == S_IDLE && state_nxt == S_SIG;
  assign par_ok  = ((^cyc_addr ^ ~cyc_is_io ^ sig[SIG_MREQ] ^ sig[SIG_RD] ^ sig[SIG_M1]) == sig[SIG_APAR])
                   && (!cyc_is_wr || ^dat == sig[SIG_DPAR]);
  // next state; the phase counter restarts on every state change
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = act_fall ? S_SIG : reg_req ? S_REGW : S_IDLE;
      S_SIG:   state_nxt = act_rise ? S_IDLE : last ? S_LO : S_SIG;
      S_LO:    state_nxt = act_rise ? S_IDLE : last ? S_HI : S_LO;
      S_HI:    state_nxt = act_rise ? S_IDLE : !last ? S_HI : cyc_is_wr ? S_BUS : S_CHECK;
      S_BUS:   state_nxt = act_rise ? S_IDLE : last ? S_CHECK : S_BUS;
      S_CHECK: state_nxt = act_rise ? S_IDLE : par_ok ? S_PUSH : retry < 8'(MAX_RETRY) ? S_SIG : S_REL;
      S_PUSH:  state_nxt = tmo_hit ? S_REL : !cyc_ready ? S_PUSH : cyc_is_wr ? S_REL : S_RSP;
      S_RSP:   state_nxt = tmo_hit ? S_REL : rsp_valid ? S_WRB : S_RSP;
      S_WRB:   state_nxt = cnt == 8'd4 ? S_REL : S_WRB;
      S_REGW:  state_nxt = cnt == 8'd4 ? S_IDLE : S_REGW;
      S_REL:   state_nxt = act_lvl ? S_IDLE : S_REL;
      default: state_nxt = S_IDLE;
    endcase
    cnt_nxt = state_nxt == state ? cnt + 8'd1 : 8'd0;
  end
  // state, captured bytes, and outputs registered from the upcoming state
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      cnt <= '0;
      {sig, lo, hi, dat, retry, tmo} <= '0;
      {CMD, D_OUT, D_OE} <= '0;
      {cyc_valid, rsp_ready, reg_ack, err_parity, err_timeout} <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      sig <= last && state == S_SIG ? D_IN : sig;
      lo  <= last && state == S_LO  ? D_IN : lo;
      hi  <= last && state == S_HI  ? D_IN : hi;
      dat <= last && state == S_BUS ? D_IN : dat;
      retry <= start ? 8'd0 : state == S_CHECK && state_nxt == S_SIG ? retry + 8'd1 : retry;
      tmo <= start ? 16'd0 : (state == S_PUSH || state == S_RSP) ? tmo + 16'd1 : tmo;
      CMD <= cmd_of(state_nxt, cnt_nxt);
      D_OE <= oe_of(state_nxt, cnt_nxt);
      D_OUT <= state == S_IDLE && state_nxt == S_REGW ? reg_data :
               state == S_RSP && state_nxt == S_WRB ? rsp_data : D_OUT;
      cyc_valid <= state_nxt == S_PUSH;
      rsp_ready <= state_nxt == S_RSP;
      reg_ack <= state_nxt == S_REGW && cnt_nxt == 8'd4;
      err_parity <= state == S_CHECK && state_nxt == S_REL;
      err_timeout <= tmo_hit;
    end
  end
endmodule
